// File: rtl/rand_way_picker.sv
// Replacement victim picker: buffers one 64-bit LFSR word and hands out IDX_W-bit slices,
// preferring invalid ways and skipping locked ones.
module rand_way_picker #(
    parameter int unsigned WAYS = 4,
    localparam int unsigned IDX_W = $clog2(WAYS),
    localparam int unsigned SLICES = 64 / IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      lfsr_i,
    output logic             update_o,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WAYS-1:0]  valid_mask,
    input  logic [WAYS-1:0]  lock_mask,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [IDX_W-1:0] resp_way,
    output logic             resp_invalid,
    output logic             resp_all_locked
);

    localparam logic [6:0] IDX_W7  = 7'(IDX_W);
    localparam logic [6:0] SLICES7 = 7'(SLICES);

    typedef enum logic [1:0] {EMPTY, ACTIVE, RESP} state_t;

    state_t           r_state;
    logic [63:0]      r_pool;
    logic [6:0]       r_slice_cnt;
    logic             r_update;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic [IDX_W-1:0] r_resp_way;
    logic             r_resp_invalid;
    logic             r_resp_all_locked;

    logic [WAYS-1:0]  w_free;
    logic             w_all_locked;
    logic [63:0]      w_shifted;
    logic [IDX_W-1:0] w_cand;
    logic [IDX_W-1:0] w_free_way;
    logic [IDX_W-1:0] w_scan_way;

    assign w_free       = ~valid_mask & ~lock_mask;
    assign w_all_locked = &lock_mask;
    // Leftover bits above SLICES*IDX_W are never reached since slice_cnt < SLICES here.
    assign w_shifted    = r_pool >> (r_slice_cnt * IDX_W7);
    assign w_cand       = w_shifted[IDX_W-1:0];

    always_comb begin
        w_free_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_free_way = IDX_W'(i);
            end
        end
    end

    // Upward scan from the candidate; IDX_W-bit addition wraps modulo WAYS.
    always_comb begin
        logic [IDX_W-1:0] w_idx;
        logic             w_found;
        w_scan_way = w_cand;
        w_idx      = w_cand;
        w_found    = 1'b0;
        for (int k = 0; k < WAYS; k++) begin
            w_idx = w_cand + IDX_W'(k);
            if (!w_found && !lock_mask[w_idx]) begin
                w_scan_way = w_idx;
                w_found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= EMPTY;
            r_pool            <= '0;
            r_slice_cnt       <= '0;
            r_update          <= 1'b0;
            r_req_ready       <= 1'b0;
            r_resp_valid      <= 1'b0;
            r_resp_way        <= '0;
            r_resp_invalid    <= 1'b0;
            r_resp_all_locked <= 1'b0;
        end else begin
            r_update <= 1'b0;
            unique case (r_state)
                EMPTY: begin
                    r_pool      <= lfsr_i;
                    r_slice_cnt <= '0;
                    r_update    <= 1'b1;
                    r_req_ready <= 1'b1;
                    r_state     <= ACTIVE;
                end
                ACTIVE: begin
                    if (req_valid) begin
                        r_req_ready       <= 1'b0;
                        r_resp_valid      <= 1'b1;
                        r_resp_invalid    <= 1'b0;
                        r_resp_all_locked <= 1'b0;
                        r_state           <= RESP;
                        if (|w_free) begin
                            r_resp_way     <= w_free_way;
                            r_resp_invalid <= 1'b1;
                        end else if (w_all_locked) begin
                            r_resp_way        <= '0;
                            r_resp_all_locked <= 1'b1;
                        end else begin
                            r_resp_way  <= w_scan_way;
                            r_slice_cnt <= r_slice_cnt + 7'd1;
                        end
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        if (r_slice_cnt == SLICES7) begin
                            r_state <= EMPTY;
                        end else begin
                            r_state     <= ACTIVE;
                            r_req_ready <= 1'b1;
                        end
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign update_o        = r_update;
    assign req_ready       = r_req_ready;
    assign resp_valid      = r_resp_valid;
    assign resp_way        = r_resp_way;
    assign resp_invalid    = r_resp_invalid;
    assign resp_all_locked = r_resp_all_locked;

endmodule
